// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: finds byte alignment from the COM symbol on a
// 1-bit lane and, once locked, delivers one byte every 8 clocks with a strobe.
module serial_paralelo_rx #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  sr;
    logic [2:0]  bit_cnt;
    logic [3:0]  bc_cnt;
    logic [7:0]  cand;
    logic        boundary;
    logic        is_comma;

    // Byte completed on the current edge, including the bit being sampled now.
    assign cand     = {sr[6:0], data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign is_comma = (cand == COMMA);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            bc_cnt    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            sr        <= cand;
            valid_out <= 1'b0;
            case (state)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt <= '0;
                        bc_cnt  <= 4'd1;
                        state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt <= bc_cnt + 4'd1;
                            if (bc_cnt + 4'd1 == 4'(BC_COUNT)) begin
                                active <= 1'b1;
                                state  <= LOCKED;
                            end
                        end else begin
                            // Sliding restarts on the following edge, not this one.
                            bc_cnt <= '0;
                            state  <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        data_out  <= cand;
                        valid_out <= !is_comma;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: streams MSB-first bytes and checks
// active, valid_out and data_out on every edge against hand-computed tables.
module tb_serial_paralelo_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    logic       bits[$];
    int         pe[$];
    logic [7:0] pd[$];
    int         de[$];
    logic [7:0] dd[$];

    serial_paralelo_rx #(.COMMA(8'hBC), .BC_COUNT(4)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clk_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        edge_n++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
    endtask

    task automatic do_reset();
        data_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        reset = 1'b0;
        edge_n = 0;
    endtask

    // act_e = edge at which active is expected to rise (0 = never in this run).
    task automatic run_stream(input string name, input int act_e);
        int n;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       has_d;
        n = bits.size();
        for (int i = 0; i < n; i++) begin
            clk_bit(bits[i]);
            exp_v = 1'b0;
            has_d = 1'b0;
            exp_d = '0;
            foreach (pe[k]) if (pe[k] == edge_n) begin
                exp_v = 1'b1; has_d = 1'b1; exp_d = pd[k];
            end
            foreach (de[k]) if (de[k] == edge_n) begin
                has_d = 1'b1; exp_d = dd[k];
            end
            chk($sformatf("%s valid@%0d", name, edge_n), 32'(valid_out), 32'(exp_v));
            chk($sformatf("%s active@%0d", name, edge_n), 32'(active),
                32'((act_e > 0) && (edge_n >= act_e)));
            if (has_d)
                chk($sformatf("%s data@%0d", name, edge_n), 32'(data_out), 32'(exp_d));
        end
        bits.delete(); pe.delete(); pd.delete(); de.delete(); dd.delete();
    endtask

    initial begin
        // Async reset takes effect with no clock edge.
        #1 reset = 1'b1;
        #1;
        chk("por data", 32'(data_out), 32'h00);
        chk("por valid", 32'(valid_out), 32'h0);
        chk("por active", 32'(active), 32'h0);
        do_reset();

        // Lock from clean reset, then two payload bytes.
        repeat (4) push_byte(8'hBC);
        push_byte(8'h55); push_byte(8'hAA);
        pe.push_back(40); pd.push_back(8'h55);
        pe.push_back(48); pd.push_back(8'hAA);
        de.push_back(32); dd.push_back(8'h00);
        run_stream("lock", 32);

        // Three junk bits shift alignment to offset 3.
        do_reset();
        bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1);
        repeat (4) push_byte(8'hBC);
        push_byte(8'h3C);
        pe.push_back(43); pd.push_back(8'h3C);
        run_stream("misalign", 35);

        // Non-COM after three COMs restarts the count.
        do_reset();
        repeat (3) push_byte(8'hBC);
        push_byte(8'h00);
        repeat (4) push_byte(8'hBC);
        push_byte(8'h7E);
        pe.push_back(72); pd.push_back(8'h7E);
        run_stream("broken", 64);

        // COM while locked is idle: data updates, no strobe.
        do_reset();
        repeat (4) push_byte(8'hBC);
        push_byte(8'h12); push_byte(8'hBC); push_byte(8'h34);
        pe.push_back(40); pd.push_back(8'h12);
        pe.push_back(56); pd.push_back(8'h34);
        de.push_back(48); dd.push_back(8'hBC);
        run_stream("idle", 32);

        // Reset mid-byte while locked.
        do_reset();
        repeat (4) push_byte(8'hBC);
        push_byte(8'hA5);
        pe.push_back(40); pd.push_back(8'hA5);
        run_stream("prelock", 32);
        bits.push_back(1'b1); bits.push_back(1'b1); bits.push_back(1'b0);
        run_stream("midbyte", 1);
        #3 reset = 1'b1;
        #1;
        chk("rst async data", 32'(data_out), 32'h00);
        chk("rst async valid", 32'(valid_out), 32'h0);
        chk("rst async active", 32'(active), 32'h0);
        repeat (3) @(posedge clk_32f);
        #1;
        chk("rst held active", 32'(active), 32'h0);
        reset = 1'b0;
        edge_n = 0;
        repeat (4) push_byte(8'hBC);
        push_byte(8'h81);
        pe.push_back(40); pd.push_back(8'h81);
        run_stream("relock", 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
